// File: rtl/shift_normalizer.sv
// Sequential leading-zero normalizer: shifts a word left until its MSB is set and reports the shift count.
// Optional FAST_STEP_EN: examine the top two bits per clock and step by two when both are zero.
module shift_normalizer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] shift_count,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_work;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] w_work_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  logic [WIDTH-1:0] r_dout;
  logic [CNT_W-1:0] r_shift_count;
  logic             r_zero;
  logic             r_out_valid;

  logic w_in_ready;
  logic w_din_zero;
  logic w_accept;
  logic w_detect;
  logic w_release;

  assign w_din_zero = (din == '0);
  assign w_accept   = in_valid && w_in_ready;
  assign w_detect   = (r_state == S_SHIFT) && r_work[WIDTH-1];
  assign w_release  = r_out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_din_zero ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_work[WIDTH-1]) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_release) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: only in_ready is combinational
  always_comb begin
    w_in_ready = (r_state == S_IDLE);
  end

  // Shift step; a nonzero word in SHIFT with top bits 00 still has >= 2 zeros, so count stays <= WIDTH-1
  always_comb begin
    w_work_nxt  = r_work << 1;
    w_count_nxt = r_count + CNT_W'(1);
`ifdef FAST_STEP_EN
    if (r_work[WIDTH-1:WIDTH-2] == 2'b00) begin
      w_work_nxt  = r_work << 2;
      w_count_nxt = r_count + CNT_W'(2);
    end
`endif
  end

  // Work register and running count carry no reset; they are always reloaded on accept
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_work  <= din;
      r_count <= '0;
    end else if ((r_state == S_SHIFT) && !r_work[WIDTH-1]) begin
      r_work  <= w_work_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Result registers: captured on entry to DONE, held after handoff
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout        <= '0;
      r_shift_count <= '0;
      r_zero        <= 1'b0;
      r_out_valid   <= 1'b0;
    end else if (w_accept && w_din_zero) begin
      r_dout        <= '0;
      r_shift_count <= CNT_W'(WIDTH);
      r_zero        <= 1'b1;
      r_out_valid   <= 1'b1;
    end else if (w_detect) begin
      r_dout        <= r_work;
      r_shift_count <= r_count;
      r_zero        <= 1'b0;
      r_out_valid   <= 1'b1;
    end else if (w_release) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign dout        = r_dout;
  assign shift_count = r_shift_count;
  assign zero        = r_zero;

endmodule

// File: tb/tb_shift_normalizer.sv
// Bench for shift_normalizer (WIDTH=8): directed cases plus random words against a leading-zero model.
module tb_shift_normalizer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] din = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] dout;
  logic [CNT_W-1:0] shift_count;
  logic             zero;

  int vectors = 0;
  int miscompares = 0;

  shift_normalizer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din        (din),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout       (dout),
    .shift_count(shift_count),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count leading zeros by scanning from the MSB
  function automatic int ref_lzc(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return 7 - i;
    end
    return 8;
  endfunction

  function automatic int ref_latency(input logic [7:0] v);
    int k;
    k = ref_lzc(v);
    if (k == 8) return 0;
`ifdef FAST_STEP_EN
    return (k / 2) + (k % 2) + 1;
`else
    return k + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word, wait for the result, hold it for 'hold' cycles (optionally poking in_valid), then take it
  task automatic run_word(input logic [7:0] v, input int hold, input bit poke);
    int edges;
    int k;
    logic [7:0] exp_dout;
    k = ref_lzc(v);
    exp_dout = (k == 8) ? 8'h00 : 8'(v << k);
    edges = 0;
    while (!in_ready && edges < 40) begin
      tick();
      edges++;
    end
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    din = v;
    tick();
    in_valid = 1'b0;
    din = 8'hA5;
    edges = 0;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
    check("latency", 32'(edges), 32'(ref_latency(v)));
    check("dout", 32'(dout), 32'(exp_dout));
    check("shift_count", 32'(shift_count), 32'(k));
    check("zero", 32'(zero), 32'(v == 8'h00));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        in_valid = 1'b1;
        din = 8'hFF;
      end
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_dout", 32'(dout), 32'(exp_dout));
      check("hold_count", 32'(shift_count), 32'(k));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handoff_valid", 32'(out_valid), 32'd0);
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    check("handoff_dout_kept", 32'(dout), 32'(exp_dout));
    check("handoff_count_kept", 32'(shift_count), 32'(k));
  endtask

  initial begin
    logic [7:0] v;
    // Reset state
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_count", 32'(shift_count), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases
    run_word(8'h80, 0, 1'b0);
    run_word(8'h01, 0, 1'b0);
    run_word(8'h13, 1, 1'b0);
    run_word(8'h00, 0, 1'b0);
    run_word(8'h20, 5, 1'b1);
    run_word(8'h04, 0, 1'b0);

    // Reset during SHIFT discards the operation
    in_valid = 1'b1;
    din = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_dout_from_last", 32'(dout), 32'h80);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_count", 32'(shift_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    run_word(8'h40, 0, 1'b0);

    // Reset during DONE
    in_valid = 1'b1;
    din = 8'h00;
    tick();
    in_valid = 1'b0;
    check("done_zero_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("done_rst_valid", 32'(out_valid), 32'd0);
    check("done_rst_zero", 32'(zero), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Random words, biased toward many leading zeros
    for (int n = 0; n < 60; n++) begin
      v = 8'($urandom_range(0, 255) >> $urandom_range(0, 8));
      run_word(v, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
